mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store sequencer between the pipeline MEM stage and the word-only data memory. Accepts one byte, halfword or word access at a time over a valid/ready handshake. Sub-word stores are performed as read-modify-write, because the memory writes whole words only. Loads are byte-extracted and sign/zero-extended, and misaligned or out-of-range addresses are reported as errors with no memory access.

Parameters:
ADDR_W, 10, word-address width of the data memory; memory depth is 2**ADDR_W words.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset, synchronous, active-high.
req_valid  in  1  access request present.
req_ready  out  1  unit can accept a request; high only in IDLE.
req_op  in  3  0=LB, 1=LH, 2=LW, 3=LBU, 4=LHU, 5=SB, 6=SH, 7=SW.
req_addr  in  32  byte address.
req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
resp_valid  out  1  response present; held until accepted.
resp_ready  in  1  consumer accepts the response.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned or out-of-range access.
dm_address  out  ADDR_W  word address to the data memory (byte address bits [ADDR_W+1:2]).
dm_wen  out  1  data memory write enable.
dm_write_data  out  32  word written to the data memory.
dm_read_data  in  32  combinational read word from the data memory.

Behaviour:
- Reset state: IDLE. resp_valid=0, resp_rdata=0, resp_err=0, latched op/addr/data=0, dm_address=0.
- dm_wen = (state==WR) && !rst. No write occurs in a reset cycle.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1. The accept edge is the edge where req_valid && req_ready.
  - On accept, latch op, addr and wdata.
  - Error check: LH/LHU/SH need addr[0]==0. LW/SW need addr[1:0]==0. Any addr bit above ADDR_W+1 set is an error.
  - Error -> RESP with resp_err=1, resp_rdata=0.
  - SW -> WR. All other ops -> RD.
- RD: dm_address = latched addr[ADDR_W+1:2].
  - Load: extract the lane, extend it, register it into resp_rdata, then -> RESP.
  - SB/SH: merge the store lane into dm_read_data, register the merged word, then -> WR.
- WR: dm_address as in RD. dm_write_data = merged word (SB/SH) or latched wdata (SW). Write occurs at this edge, then -> RESP.
- RESP: resp_valid=1. The response is stable until resp_ready is high at an edge, then -> IDLE. req_ready=0 throughout.
- Byte order is little-endian:
  - byte lane k = bits [8k+7:8k], k = addr[1:0].
  - halfword lane = bits [15:0] when addr[1]=0, [31:16] when addr[1]=1.
- Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Merge: SB replaces only byte lane k with wdata[7:0]. SH replaces only its halfword with wdata[15:0]. All other bits keep the old word.
- Latency, in edges from accept edge T to resp_valid high:
  - error: resp_valid high in cycle T+1.
  - load or SW: T+2.
  - SB/SH: T+3.
- Back-to-back: a new request can be accepted the cycle after the RESP handshake. There is no overlap.
- Reset mid-operation: any state returns to IDLE, a pending response is dropped, and no write is issued in the reset cycle.
- req_valid in non-IDLE states is ignored (req_ready=0). Request inputs need only be stable on the accept edge.

Test Plan:
- Reset: assert rst 2 cycles while req_valid=1, op=SW -> dm_wen never 1, resp_valid=0, req_ready=1 after release.
- SW/LW: SW addr 0x10, data 0xDEADBEEF -> dm_wen for 1 cycle, dm_address=4, resp at T+2, err=0. Then LW 0x10 -> resp_rdata=0xDEADBEEF at T+2.
- Sub-word store:
  - Prefill word 4 with 0x11223344.
  - SB addr 0x12, data 0xAA -> memory 0x11AA3344 at T+3.
  - SH addr 0x12, data 0xBEEF -> memory 0xBEEF3344.
- Loads from word 0x80FF7F01:
  - LB at byte offset 2 -> 0xFFFFFFFF.
  - LBU at offset 2 -> 0x000000FF.
  - LH at offset 2 -> 0xFFFF80FF.
  - LHU at offset 0 -> 0x00007F01.
- Errors, each -> resp_err=1, rdata=0 at T+1, no dm_wen:
  - LW addr 0x2.
  - SH addr 0x1.
  - SW addr with bit ADDR_W+2 set.
- Backpressure and abort:
  - Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable and req_ready=0. Release -> next request accepted the following cycle.
  - Assert rst while in WR -> no write, state IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-only data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// RD     | word read; load extract/extend or sub-word store merge
// WR     | full-word write to the data memory
// RESP   | response held until resp_ready
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_address,
  output logic              dm_wen,
  output logic [31:0]       dm_write_data,
  input  logic [31:0]       dm_read_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  // Byte-address bits above the memory's reach make the access out of range.
  localparam logic [31:0] HI_MASK = ~((32'h1 << (ADDR_W + 2)) - 32'h1);

  logic [1:0]        state_q,  state_d;
  logic [2:0]        op_q,     op_d;
  logic [ADDR_W+1:0] addr_q,   addr_d;
  logic [31:0]       wdata_q,  wdata_d;
  logic [31:0]       merged_q, merged_d;
  logic [31:0]       rdata_q,  rdata_d;
  logic              err_q,    err_d;

  logic        misalign;
  logic        range_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [3:0]  byte_en;
  logic [31:0] wlane;
  logic [31:0] merged;

  always_comb begin
    misalign = 1'b0;
    case (req_op)
      OP_LH, OP_LHU, OP_SH: misalign = req_addr[0];
      OP_LW, OP_SW:         misalign = |req_addr[1:0];
      default:              misalign = 1'b0;
    endcase
  end

  assign range_err = |(req_addr & HI_MASK);

  always_comb begin
    rd_byte = dm_read_data[7:0];
    case (addr_q[1:0])
      2'd0: rd_byte = dm_read_data[7:0];
      2'd1: rd_byte = dm_read_data[15:8];
      2'd2: rd_byte = dm_read_data[23:16];
      default: rd_byte = dm_read_data[31:24];
    endcase
    rd_half = addr_q[1] ? dm_read_data[31:16] : dm_read_data[15:0];
  end

  always_comb begin
    load_ext = dm_read_data;
    case (op_q)
      OP_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_ext = {24'h0, rd_byte};
      OP_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_ext = {16'h0, rd_half};
      default: load_ext = dm_read_data;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    byte_en = 4'b0000;
    wlane   = {4{wdata_q[7:0]}};
    if (op_q == OP_SB) begin
      byte_en = 4'b0001 << addr_q[1:0];
    end else if (op_q == OP_SH) begin
      byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      wlane   = {2{wdata_q[15:0]}};
    end
    merged = dm_read_data;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = byte_en[k] ? wlane[8*k +: 8] : dm_read_data[8*k +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          if (misalign || range_err) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_op == OP_SW) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (op_q == OP_SB || op_q == OP_SH) begin
          merged_d = merged;
          state_d  = S_WR;
        end else begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end
      end
      S_WR: state_d = S_RESP;
      default: begin
        if (resp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign dm_address    = addr_q[ADDR_W+1:2];
  assign dm_wen        = (state_q == S_WR) && !rst;
  assign dm_write_data = (op_q == OP_SW) ? wdata_q : merged_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random traffic against a
// word-array reference model of the data memory.
module tb_mem_access_unit;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] dm_address;
  logic          dm_wen;
  logic [31:0]   dm_write_data;
  logic [31:0]   dm_read_data;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_address(dm_address), .dm_wen(dm_wen),
    .dm_write_data(dm_write_data), .dm_read_data(dm_read_data)
  );

  always #5 clk = ~clk;

  assign dm_read_data = mem[dm_address];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    forever begin
      @(posedge clk);
      if (dm_wen) mem[dm_address] <= dm_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: access size, alignment and range rules applied to a plain word array.
  task automatic predict(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat, output int wen);
    int unsigned idx, size, sh;
    logic [31:0] w, v, m;
    idx  = int'(addr[AW+1:2]);
    w    = ref_mem[idx];
    size = (op == 3'd2 || op == 3'd7) ? 4 : (op == 3'd1 || op == 3'd4 || op == 3'd6) ? 2 : 1;
    err  = ((addr >> (AW + 2)) != 0) || ((addr % size) != 0);
    sh   = 8 * int'(addr[1:0]);
    rd   = 32'h0;
    wen  = 0;
    if (err) begin
      lat = 1;
    end else if (op < 3'd5) begin
      lat = 2;
      m   = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
      v   = (w >> sh) & m;
      if (op == 3'd0 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
      if (op == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      rd = v;
    end else begin
      wen = 1;
      lat = (op == 3'd7) ? 2 : 3;
      m   = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
      ref_mem[idx] = (w & ~(m << sh)) | ((wd & m) << sh);
    end
  endtask

  task automatic access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] got);
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat, e_wen, lat, wen_cnt;
    logic [AW-1:0] e_idx;
    e_idx = addr[AW+1:2];
    predict(op, addr, wd, e_rd, e_err, e_lat, e_wen);
    @(negedge clk);
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    // Request inputs must be ignored while busy.
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    wen_cnt = 0;
    while (!resp_valid && lat < 20) begin
      chk("busy_ready", {31'h0, req_ready}, 32'h0);
      if (dm_wen) begin
        wen_cnt++;
        chk("wr_addr", 32'(dm_address), 32'(e_idx));
      end
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    chk("latency", 32'(lat), 32'(e_lat));
    chk("resp_err", {31'h0, resp_err}, {31'h0, e_err});
    chk("resp_rdata", resp_rdata, e_rd);
    chk("wen_count", 32'(wen_cnt), 32'(e_wen));
    got = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_rdata", resp_rdata, got);
      chk("hold_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_valid", {31'h0, resp_valid}, 32'h0);
    chk("post_ready", {31'h0, req_ready}, 32'h1);
  endtask

  logic [31:0] got;
  logic [2:0]  r_op;
  logic [31:0] r_addr;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_op     = 3'd7;
    req_addr   = 32'h10;
    req_wdata  = 32'hCAFE_F00D;
    resp_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_wen", {31'h0, dm_wen}, 32'h0);
      chk("rst_valid", {31'h0, resp_valid}, 32'h0);
    end
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_addr", 32'(dm_address), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);

    access(3'd7, 32'h10, 32'hDEAD_BEEF, 0, got);
    access(3'd2, 32'h10, 32'h0, 0, got);
    chk("lw_deadbeef", got, 32'hDEAD_BEEF);

    access(3'd7, 32'h10, 32'h1122_3344, 0, got);
    access(3'd5, 32'h12, 32'h0000_00AA, 0, got);
    chk("sb_mem", mem[4], 32'h11AA_3344);
    access(3'd6, 32'h12, 32'h0000_BEEF, 0, got);
    chk("sh_mem", mem[4], 32'hBEEF_3344);

    access(3'd7, 32'h20, 32'h80FF_7F01, 0, got);
    access(3'd0, 32'h22, 32'h0, 0, got);
    chk("lb_sext", got, 32'hFFFF_FFFF);
    access(3'd3, 32'h22, 32'h0, 0, got);
    chk("lbu_zext", got, 32'h0000_00FF);
    access(3'd1, 32'h22, 32'h0, 0, got);
    chk("lh_sext", got, 32'hFFFF_80FF);
    access(3'd4, 32'h20, 32'h0, 0, got);
    chk("lhu_zext", got, 32'h0000_7F01);

    access(3'd2, 32'h2, 32'h0, 0, got);
    access(3'd6, 32'h1, 32'h1234, 0, got);
    access(3'd7, 32'h1 << (AW + 2), 32'h5555_AAAA, 0, got);

    access(3'd2, 32'h20, 32'h0, 5, got);
    chk("bp_rdata", got, 32'h80FF_7F01);

    // Abort in WR: the write must not land.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd7;
    req_addr  = 32'h30;
    req_wdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_wr", {31'h0, dm_wen}, 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_wen", {31'h0, dm_wen}, 32'h0);
    @(posedge clk); #1;
    chk("abort_mem", mem[12], ref_mem[12]);
    chk("abort_valid", {31'h0, resp_valid}, 32'h0);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 200; n++) begin
      r_op   = 3'($urandom);
      r_addr = {24'h0, 4'($urandom), 2'($urandom), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) r_addr = r_addr | (32'h1 << $urandom_range(AW + 2, 31));
      access(r_op, r_addr, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, got);
    end
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
